// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store bridge between the core and the Avalon master.
package mem_access_pkg;

  // Access size encoding as presented by the core
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte lanes touched by an access of the given size at the given word offset
  function automatic logic [3:0] calc_byteenable(input size_e size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << offset;
      SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byteenable/replicated data, load extract/extend,
// and detection of accesses that must not reach the bus.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic [31:0] o_load_data,
  output logic        o_bad
);

  logic [31:0] w_lane;

  // Steer store data, extract load data and flag misaligned or reserved-size accesses
  always_comb begin
    w_lane       = i_rdata >> {i_offset, 3'b000};
    o_byteenable = calc_byteenable(i_size, i_offset);
    case (i_size)
      SZ_BYTE: begin
        o_writedata = {4{i_wdata[7:0]}};
        o_load_data = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
        o_bad       = 1'b0;
      end
      SZ_HALF: begin
        o_writedata = {2{i_wdata[15:0]}};
        o_load_data = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
        o_bad       = i_offset[0];
      end
      SZ_WORD: begin
        o_writedata = i_wdata;
        o_load_data = i_rdata;
        o_bad       = (i_offset != 2'b00);
      end
      default: begin
        o_writedata = i_wdata;
        o_load_data = i_rdata;
        o_bad       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bridge: one core data request at a time becomes one word-aligned Avalon
// transaction, held stable across waitrequest, with the extended load result returned.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic [DATA_W-1:0] readdata
);

  state_e            r_state;
  logic              r_ready;
  logic              r_read;
  logic              r_write;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writedata;
  logic [3:0]        r_byteenable;
  size_e             r_size;
  logic [1:0]        r_offset;
  logic              r_signed;

  size_e             w_size;
  logic [1:0]        w_offset;
  logic              w_signed;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load;
  logic              w_bad;

  // The aligner sees the live request while idle and the captured request during the bus phase
  assign w_size   = (r_state == IDLE) ? size_e'(req_size) : r_size;
  assign w_offset = (r_state == IDLE) ? req_addr[1:0]     : r_offset;
  assign w_signed = (r_state == IDLE) ? req_signed        : r_signed;

  mem_lane_align u_align (
    .i_size       (w_size),
    .i_offset     (w_offset),
    .i_signed     (w_signed),
    .i_wdata      (req_wdata),
    .i_rdata      (readdata),
    .o_byteenable (w_be),
    .o_writedata  (w_wdata),
    .o_load_data  (w_load),
    .o_bad        (w_bad)
  );

  // Request sequencing with all bus and response outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= 4'b0000;
      r_size       <= SZ_BYTE;
      r_offset     <= 2'b00;
      r_signed     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_ready <= 1'b0;
            if (w_bad) begin
              // Rejected accesses never touch the bus
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state      <= BUS;
              r_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              r_byteenable <= w_be;
              r_writedata  <= w_wdata;
              r_offset     <= req_addr[1:0];
              r_size       <= size_e'(req_size);
              r_signed     <= req_signed;
              r_write      <= req_write;
              r_read       <= ~req_write;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_state      <= RESP;
            if (r_read) begin
              r_resp_rdata <= w_load;
            end
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_ready      <= 1'b1;
          r_read       <= 1'b0;
          r_write      <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign read       = r_read;
  assign write      = r_write;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: a byte-addressed memory model predicts responses and bus beats,
// a word-wide Avalon slave model serves the DUT, and monitors compare on the falling edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        write, read, waitrequest;
  logic [3:0]  byteenable;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
    int          stalls;
  } bus_t;

  resp_t       sb_q[$];
  bus_t        bus_q[$];
  logic [31:0] slave_mem [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  logic [31:0] model_last = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_left = 0;
  bit          noise_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] wa);
    if (slave_mem.exists(wa)) return slave_mem[wa];
    return 32'h0;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    slave_mem[wa & ~32'h3] = val;
    for (int i = 0; i < 4; i++) model_mem[(wa & ~32'h3) + i] = val[8*i +: 8];
  endtask

  // Avalon slave: commits writes at the edge, then presents stall and read data for the new cycle
  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      stall_left = 0;
    end else if (write && !waitrequest) begin
      w = slave_word(address);
      for (int i = 0; i < 4; i++) if (byteenable[i]) w[8*i +: 8] = writedata[8*i +: 8];
      slave_mem[address] = w;
    end
    #1;
    if (read || write) begin
      if (stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
      end else begin
        waitrequest = 1'b0;
      end
      readdata = slave_word(address);
    end else begin
      waitrequest = 1'($urandom_range(1));
      readdata    = $urandom;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid
  always @(negedge clk) begin
    resp_t e;
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid required=none (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Bus monitor: checks each transaction against the model and its stability under stall
  bus_t        cur;
  bit          in_txn = 1'b0;
  int          bus_cycles = 0;
  always @(negedge clk) begin
    if (reset || !(read || write)) begin
      in_txn = 1'b0;
    end else begin
      check("rw_exclusive", {31'b0, read & write}, 32'h0);
      if (!in_txn) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus actual=addr_%h required=no_access (t=%0t)", address, $time);
          cur.addr = address; cur.be = byteenable; cur.wdata = writedata;
          cur.wr = write; cur.stalls = 0;
        end else begin
          cur = bus_q.pop_front();
          check("bus_addr", address, cur.addr);
          check("bus_be", {28'b0, byteenable}, {28'b0, cur.be});
          check("bus_write", {31'b0, write}, {31'b0, cur.wr});
          if (cur.wr) check("bus_wdata", writedata, cur.wdata);
        end
        in_txn     = 1'b1;
        bus_cycles = 0;
      end else begin
        check("hold_addr", address, cur.addr);
        check("hold_be", {28'b0, byteenable}, {28'b0, cur.be});
        if (cur.wr) check("hold_wdata", writedata, cur.wdata);
      end
      bus_cycles++;
      if (!waitrequest) begin
        check("bus_cycles", bus_cycles, cur.stalls + 1);
        in_txn = 1'b0;
      end
    end
  end

  // Issue one request from a falling edge; predicts response and bus beat from byte-level rules
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int st);
    int          n;
    bit          bad;
    resp_t       r;
    bus_t        b;
    logic [31:0] val;
    for (int k = 0; k < 200 && !req_ready; k++) begin
      if (noise_en) begin
        req_valid  = 1'($urandom_range(1));
        req_write  = 1'($urandom_range(1));
        req_size   = 2'($urandom_range(3));
        req_signed = 1'($urandom_range(1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 (t=%0t)", $time);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; stall_left = st;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = (sz == 2'b11) || ((a % n) != 0);
    r.err = bad;
    r.cyc = cyc + (bad ? 1 : 2 + st);
    if (!bad) begin
      b.addr = a & ~32'h3; b.wr = wr; b.stalls = st; b.be = 4'b0000;
      for (int i = 0; i < n; i++) b.be[(a % 4) + i] = 1'b1;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      if (wr) begin
        for (int i = 0; i < n; i++) model_mem[a + i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = model_byte(a + i);
        if (sg && n < 4 && val[8*n-1]) for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
        model_last = val;
      end
      bus_q.push_back(b);
    end
    r.rdata = model_last;
    sb_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_read", {31'b0, read}, 32'h0);
    check("rst_write", {31'b0, write}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_byteenable", {28'b0, byteenable}, 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Directed scenarios
    preload(32'h1004, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0);
    preload(32'h2000, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 0);
    preload(32'h3000, 32'h55667788);
    issue(1'b1, 2'b01, 1'b0, 32'h3002, 32'h1234ABCD, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h4002, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h4001, 32'hCAFEF00D, 0);

    // Reset while a load is stalled on the bus
    preload(32'h6000, 32'h13572468);
    issue(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 6);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    void'(sb_q.pop_back());
    model_last = 32'h0;
    check("rstmid_read", {31'b0, read}, 32'h0);
    check("rstmid_ready", {31'b0, req_ready}, 32'h1);
    check("rstmid_rdata", resp_rdata, 32'h0);
    #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    preload(32'h5000, 32'h0000AB00);
    issue(1'b0, 2'b00, 1'b0, 32'h5001, 32'h0, 0);

    // Randomized traffic over a small preloaded window, with noise on req_* while busy
    for (int i = 0; i < 16; i++) preload(32'h100 + 4*i, $urandom);
    noise_en = 1'b1;
    for (int t = 0; t < 120; t++) begin
      issue(1'($urandom_range(1)),
            ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2)),
            1'($urandom_range(1)),
            32'h100 + 32'($urandom_range(63)),
            $urandom,
            $urandom_range(3));
    end
    noise_en = 1'b0;

    for (int k = 0; k < 300 && sb_q.size() > 0; k++) @(negedge clk);
    check("drain_resp", sb_q.size(), 32'h0);
    check("drain_bus", bus_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store bridge between the multicycle MIPS core datapath and the Avalon memory-mapped master port.
- Accepts one data-memory request at a time: byte, half or word, signed or unsigned, load or store.
- Turns each request into a single word-aligned Avalon transaction with the correct byteenable, and holds it stable across waitrequest.
- Returns the lane-extracted, extended load result and flags misaligned accesses without touching the bus.

Parameters:
- ADDR_W, 32, byte-address width on both core side and bus side
- DATA_W, 32, bus data width; only 32 is supported

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core presents a request this cycle
- req_ready  output  1  unit is idle and can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address from the ALU result
- req_wdata  input  32  store data (rt); only the low bits are used for byte/half
- resp_valid  output  1  one-cycle pulse: request complete
- resp_err  output  1  qualifies resp_valid: misaligned or reserved size
- resp_rdata  output  32  extended load data; held until the next resp_valid
- address  output  32  Avalon address, always word aligned
- write  output  1  Avalon write strobe
- read  output  1  Avalon read strobe
- waitrequest  input  1  Avalon stall
- writedata  output  32  Avalon write data, lane-replicated
- byteenable  output  4  Avalon byte lanes
- readdata  input  32  Avalon read data

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: state IDLE; req_ready=1; read=0; write=0; resp_valid=0; resp_err=0; resp_rdata=0; address=0; writedata=0; byteenable=0.
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. When req_valid=1 at a posedge:
  - If misaligned or size=11: go to RESP with resp_err=1. No bus activity.
  - Otherwise: register address={req_addr[31:2],2'b00}, byteenable, writedata, lane offset, size and signed; go to BUS.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- BUS: read=!req_write_q, write=req_write_q. Read and write are never high together.
  - address, byteenable and writedata stay constant while waitrequest=1. Stay in BUS.
  - On a posedge with waitrequest=0: for a load, capture the extended readdata into resp_rdata. Go to RESP.
  - Zero-wait-state slaves complete in one BUS cycle.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in BUS and RESP.
- Latency: request accepted at edge N; read/write high during cycle N+1; with no wait states resp_valid is high during cycle N+2. Each waitrequest cycle adds one.
- byteenable:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- writedata:
  - byte: wdata[7:0] replicated x4
  - half: wdata[15:0] replicated x2
  - word: wdata unchanged
- Load extract: lane = readdata >> (8*addr[1:0]). Byte uses lane[7:0]; half uses lane[15:0]. Sign- or zero-extend to 32 bits per req_signed. Word passes through unchanged.
- Store completion: resp_valid=1 with resp_rdata unchanged.
- Ignored inputs: req_valid while req_ready=0; readdata outside BUS with waitrequest=0.
- Reset mid-transaction: at the reset edge, read/write drop and the FSM returns to IDLE. The bus slave is reset by the same signal. No response is issued.
- Address 0: an ordinary address here; halt detection is not this block's concern.

Decomposition:
- Package mem_access_pkg:
  - size enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state enum: IDLE, BUS, RESP
  - function computing byteenable from size and offset
- One sub-module, mem_lane_align: purely combinational. Produces byteenable and writedata for stores, and extracts/extends readdata for loads. It is shared by the FSM's capture paths.

Test Plan:
- Zero-wait word load: addr=0x1004, size=10, readdata=0xDEADBEEF, waitrequest=0 -> address=0x1004, byteenable=1111, read high for 1 cycle; resp_valid at N+2 with rdata=0xDEADBEEF.
- Signed byte load: addr=0x2003, size=00, signed=1, readdata=0x80FF7F01 -> byteenable=1000, rdata=0xFFFFFF80. Same access with signed=0 -> rdata=0x00000080.
- Half store with 3 wait cycles: addr=0x3002, size=01, wdata=0x1234ABCD, waitrequest high for 3 cycles -> write=1 for 4 cycles; address=0x3000, byteenable=1100 and writedata=0xABCDABCD stable throughout; a single resp_valid.
- Misaligned word: addr=0x4002, size=10 -> no read/write ever asserted; resp_valid=1 with resp_err=1 one cycle after acceptance. Same result for size=11.
- Reset mid-BUS: a load stalled by waitrequest, reset pulsed for 1 cycle -> read=0 and req_ready=1 after the reset edge, no resp_valid. A following byte load at 0x5001 with readdata=0x0000AB00 then completes with rdata=0x000000AB (unsigned).
